// File: rtl/timer_counter_pkg.sv
// Shared register map, CTRL field positions, mode codes and FSM encoding
// for the memory-mapped countdown timer.
package timer_counter_pkg;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int CTRL_W   = 4;
    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    // Codes 1x fall back to one-shot, so only the exact reload code reloads.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT registers on a word bus; expiry
// sets a sticky flag that drives irq when the interrupt mask bit allows it.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    logic [1:0]        state_q,  state_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q,  count_d;
    logic              flag_q,   flag_d;
    logic              en;

    assign en = ctrl_q[EN_BIT];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q <= WIDTH'(1)) begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = INT;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            INT: begin
                state_d = IDLE;
                if (is_reload(ctrl_q[MODE_MSB:MODE_LSB])) flag_d = 1'b0;
                else                                      ctrl_d[EN_BIT] = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Bus writes come last so they override any FSM update of EN or the flag.
        if (we) begin
            case (addr)
                CTRL_OFS: begin
                    ctrl_d = din[CTRL_W-1:0];
                    flag_d = 1'b0;
                end
                PRESET_OFS: preset_d = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values, avoiding order-dependent races.
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            CTRL_OFS:   dout = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
            PRESET_OFS: dout = preset_q;
            COUNT_OFS:  dout = count_q;
            default:    dout = '0;
        endcase
    end

    assign irq = ctrl_q[IM_BIT] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a one-shot vector table plus hand-written
// sequences for reload, pause, masking, boundary presets and async reset.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    timer_counter #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        din   = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // One-shot run, PRESET=5, CTRL=0x9; dout is the pre-edge read of addr.
        vecs[0]  = '{1'b1, 2'd1, 32'd5,    32'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 32'h9,    32'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'd0,    32'h9, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 32'd0,    32'd0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 32'd0,    32'd5, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'd0,    32'd4, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 32'd0,    32'd3, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'd0,    32'd2, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 32'd0,    32'd1, 1'b0};
        vecs[9]  = '{1'b0, 2'd2, 32'd0,    32'd0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 32'd0,    32'h8, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 32'h8,    32'h8, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 32'd0,    32'h8, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 32'd0,    32'd0, 1'b0};
        vecs[14] = '{1'b1, 2'd2, 32'h55,   32'd0, 1'b0};
        vecs[15] = '{1'b0, 2'd2, 32'd0,    32'd0, 1'b0};

        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        din   = '0;
        #3;
        for (int a = 0; a < 3; a++) begin
            rd_check($sformatf("reset_read_a%0d", a), 2'(a), 32'd0);
            check($sformatf("reset_irq_a%0d", a), {31'd0, irq}, 32'd0);
        end
        tick();
        rd_check("reset_held_count", 2'd2, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            we   = vecs[i].we;
            addr = vecs[i].addr;
            din  = vecs[i].din;
            #1;
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            tick();
            we = 1'b0;
        end
        rd_check("oneshot_preset_kept", 2'd1, 32'd5);

        // Auto-reload, PRESET=3: pulses at E5, E11, E17.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 17; e++) begin
            tick();
            check($sformatf("reload_irq_E%0d", e), {31'd0, irq},
                  {31'd0, (e == 5 || e == 11 || e == 17)});
        end
        rd_check("reload_ctrl_en_kept", 2'd0, 32'hB);

        // Pause: the write lands on the edge where COUNT goes 7->6.
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rd_check("pause_pre_count", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        repeat (8) tick();
        rd_check("pause_count_held", 2'd2, 32'd6);
        check("pause_irq", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        rd_check("pause_load_cycle", 2'd2, 32'd6);
        tick();
        rd_check("pause_reloaded", 2'd2, 32'd10);

        // Masking: expiry with IM=0 leaves the flag set but irq low.
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("mask_irq_E%0d", e), {31'd0, irq}, 32'd0);
        end
        rd_check("mask_ctrl_cleared", 2'd0, 32'h0);
        rd_check("mask_count_zero", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        check("mask_irq_after_im", {31'd0, irq}, 32'd0);

        // PRESET=0 expires at E3 like PRESET=1; then async reset drops irq.
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        check("p0_irq_E1", {31'd0, irq}, 32'd0);
        tick();
        check("p0_irq_E2", {31'd0, irq}, 32'd0);
        tick();
        check("p0_irq_E3", {31'd0, irq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("p0_async_reset_irq", {31'd0, irq}, 32'd0);

        // PRESET rewritten mid-count affects only the next reload.
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        tick();
        tick();
        rd_check("pw_count_E2", 2'd2, 32'd4);
        wr(2'd1, 32'd2);
        rd_check("pw_count_E3", 2'd2, 32'd3);
        tick();
        rd_check("pw_count_E4", 2'd2, 32'd2);
        tick();
        rd_check("pw_count_E5", 2'd2, 32'd1);
        tick();
        check("pw_irq_E6", {31'd0, irq}, 32'd1);
        rd_check("pw_count_E6", 2'd2, 32'd0);
        tick();
        check("pw_irq_E7", {31'd0, irq}, 32'd0);
        tick();
        tick();
        rd_check("pw_reload_new_preset", 2'd2, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_count", dout, 32'd0);
        rd_check("async_reset_preset", 2'd1, 32'd0);
        check("async_reset_irq", {31'd0, irq}, 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
